// File: rtl/paddsb_seq_if.sv
// Handshake bundle for paddsb_seq: operand/mode input channel and result output channel.
// The master modport is the issuing side; the slave modport is the execution unit.
interface paddsb_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, Out
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, Out
  );
endinterface

// File: rtl/paddsb_seq.sv
// Iterative per-lane signed saturating add/subtract (PADDSB/PSUBSB) on four 4-bit lanes,
// one lane per cycle through a single shared 4-bit datapath, valid/ready on both sides.
module paddsb_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  paddsb_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic [15:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;

  logic [3:0]  lane_a;
  logic [3:0]  lane_b;
  logic [3:0]  lane_res;

  // Exact 5-bit signed result; overflow out of 4 bits shows as r[4] != r[3],
  // and r[4] then carries the true sign, which picks the clamp direction.
  function automatic logic [3:0] sat_lane(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       do_sub);
    logic [4:0] r;
    if (do_sub) r = {a[3], a} - {b[3], b};
    else        r = {a[3], a} + {b[3], b};
    if (r[4] != r[3]) return r[4] ? 4'h8 : 4'h7;
    return r[3:0];
  endfunction

  // Shared datapath: pick the nibble of each operand selected by the lane counter.
  always_comb begin
    lane_a = a_q[3:0];
    lane_b = b_q[3:0];
    unique case (lane_q)
      2'd0: begin lane_a = a_q[3:0];   lane_b = b_q[3:0];   end
      2'd1: begin lane_a = a_q[7:4];   lane_b = b_q[7:4];   end
      2'd2: begin lane_a = a_q[11:8];  lane_b = b_q[11:8];  end
      2'd3: begin lane_a = a_q[15:12]; lane_b = b_q[15:12]; end
      default: ;
    endcase
    lane_res = sat_lane(lane_a, lane_b, sub_q);
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sub_d   = bus.sub;
          out_d   = '0;
          lane_d  = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        unique case (lane_q)
          2'd0: out_d[3:0]   = lane_res;
          2'd1: out_d[7:4]   = lane_res;
          2'd2: out_d[11:8]  = lane_res;
          2'd3: out_d[15:12] = lane_res;
          default: ;
        endcase
        lane_d = lane_q + 2'd1;
        if (lane_q == LAST_LANE) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the operand registers are reset too, so a reset leaves
  // no stale operands or partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.Out       = out_q;

endmodule

// File: tb/tb_paddsb_seq.sv
// Self-checking bench for paddsb_seq: scoreboard of model results, one task per scenario.
module tb_paddsb_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] sb[$];

  paddsb_seq_if bus();

  paddsb_seq #(.LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: lanes as plain signed integers, clamped to [-8, 7].
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic [15:0] res;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      int va, vb, r;
      va = int'(a[l*4 +: 4]);
      vb = int'(b[l*4 +: 4]);
      if (va >= 8) va = va - 16;
      if (vb >= 8) vb = vb - 16;
      r = s ? (va - vb) : (va + vb);
      if (r > 7)  r = 7;
      if (r < -8) r = -8;
      res[l*4 +: 4] = 4'(r);
    end
    return res;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
    end
    bus.A        = a;
    bus.B        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = ~a;
    bus.B        = 16'($urandom);
    bus.sub      = ~s;
  endtask

  task automatic drain(input string tag);
    int n;
    logic [15:0] exp;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Out !== exp) begin
      failures++;
      $display("FAIL %s_result: out_valid=%b Out=%h required out_valid=1 Out=%h",
               tag, bus.out_valid, bus.Out, exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Out !== exp || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_drained: out_valid=%b Out=%h in_ready=%b required 0 %h 1",
               tag, bus.out_valid, bus.Out, bus.in_ready, exp);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.sub = 1'b0;
    #23;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Out !== 16'h0000 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: out_valid=%b Out=%h in_ready=%b required 0 0000 1",
               bus.out_valid, bus.Out, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reach DONE, then assert reset mid-cycle and look for an immediate clear.
    send(16'h3333, 16'h2222, 1'b0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async: out_valid=%b Out=%h required 0 0000",
               bus.out_valid, bus.Out);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_add_latency();
    send(16'h1234, 16'h1111, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL latency_early_%0d: out_valid=%b required 0", k, bus.out_valid);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_edge4: out_valid=%b required 1", bus.out_valid);
    end
    checks++;
    if (bus.Out !== 16'h2345) begin
      failures++;
      $display("FAIL add_plain: Out=%h required 2345", bus.Out);
    end
    drain("add_plain");
  endtask

  task automatic test_saturation();
    send(16'h7788, 16'h1188, 1'b0);
    drain("add_sat");
    send(16'h8070, 16'h1081, 1'b1);
    drain("sub_sat");
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] exp;
    send(16'h4A5C, 16'h3B6D, 1'b1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = model(16'h4A5C, 16'h3B6D, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A   = 16'($urandom);
      bus.B   = 16'($urandom);
      bus.sub = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Out !== exp) begin
        failures++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b Out=%h required 1 0 %h",
                 k, bus.out_valid, bus.in_ready, bus.Out, exp);
      end
    end
    bus.in_valid = 1'b0;
    drain("bp");
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.Out !== exp) begin
      failures++;
      $display("FAIL bp_no_extra_op: out_valid=%b in_ready=%b Out=%h required 0 1 %h",
               bus.out_valid, bus.in_ready, bus.Out, exp);
    end
  endtask

  task automatic test_reset_mid_op();
    send(16'h1234, 16'h5678, 1'b0);
    // out_ready high during CALC must not matter either.
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Out !== 16'h0000 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_reset: out_valid=%b Out=%h in_ready=%b required 0 0000 1",
               bus.out_valid, bus.Out, bus.in_ready);
    end
    sb.delete();
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0);
    drain("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta[4];
    logic [15:0] tbv[4];
    logic        ts[4];
    ta[0] = 16'h8888; tbv[0] = 16'h8888; ts[0] = 1'b0;
    ta[1] = 16'h8888; tbv[1] = 16'h7777; ts[1] = 1'b1;
    ta[2] = 16'h7777; tbv[2] = 16'h8888; ts[2] = 1'b1;
    ta[3] = 16'h0F70; tbv[3] = 16'h0111; ts[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tbv[i], ts[i]);
      drain("table");
    end
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom));
      drain("random");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_latency();
    test_saturation();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddsb_seq.md
Name: paddsb_seq

Overview:
- Multi-cycle, lane-preserving counterpart of the ALU's reduction path.
- Reduction collapses lanes into one sum; this block keeps the four 4-bit lanes independent. It computes per-lane signed saturating add or subtract (PADDSB / PSUBSB), one nibble lane per cycle, through a single shared 4-bit datapath.
- Sits beside the ALU as an iterative execution unit with a valid/ready handshake on both input and output.

Parameters:
- LANES, 4, number of 4-bit lanes in the 16-bit word. Fixed at 4; other values are not supported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode valid
- in_ready  output  1  block can accept an operation
- A  input  16  operand A, lanes A[15:12]..A[3:0]
- B  input  16  operand B, same lane layout
- sub  input  1  0 = lane add, 1 = lane subtract (A - B)
- out_valid  output  1  Out holds a completed result
- out_ready  input  1  consumer accepts result
- Out  output  16  per-lane saturated result

Behaviour:
- Clock, reset and arithmetic:
  - One clock: clk. Reset rst_n is asynchronous, active-low. Everything resets immediately on assertion.
  - Reset values: state = IDLE, lane counter = 0, Out = 16'h0000, out_valid = 0, operand and mode registers = 0.
  - in_ready = 1 exactly when state is IDLE, decoded from registered state. It is therefore 1 immediately after reset.
  - Lane arithmetic: treat a and b as signed 4-bit (-8..7). Form the exact 5-bit signed r = a + b (sub=0) or r = a - b (sub=1). Clamp: r > 7 gives 4'h7, r < -8 gives 4'h8, otherwise r[3:0].
- IDLE:
  - An in_valid && in_ready edge latches A, B and sub, clears Out to 0, sets lane counter = 0 and moves to CALC.
- CALC:
  - Each cycle computes the lane selected by the counter (lane 0 = bits [3:0] first) and writes that nibble of Out. The counter increments.
  - After lane 3 is written, go to DONE on that same edge. CALC lasts exactly 4 cycles.
- DONE:
  - out_valid = 1. Out and out_valid hold stable while out_ready = 0.
  - An out_valid && out_ready edge moves to IDLE and clears out_valid. Out keeps its value until the next accept.
- Latency and throughput:
  - If acceptance happens at edge N, out_valid is 1 after edge N+4.
  - The earliest next accept is edge N+6 (output handshake at N+5, IDLE at N+6). The input handshake and result drain never overlap.
- Boundary cases:
  - in_valid while not IDLE is ignored. Latched operands are unaffected by input changes after acceptance.
  - out_ready while not DONE is ignored.
  - Reset mid-CALC or mid-DONE aborts the operation. The state returns to reset values with no partial result presented.
  - Out during CALC is partial and not meaningful. Only sample it when out_valid = 1.
  - Lanes are fully independent: no carry or borrow crosses a lane boundary.

Test Plan:
- Reset check: drive rst_n low mid-cycle. Immediately out_valid = 0, Out = 16'h0000, and in_ready = 1 once rst_n deasserts.
- Plain add, latency: A = 16'h1234, B = 16'h1111, sub = 0. Out = 16'h2345, with out_valid rising exactly 4 cycles after the accept edge.
- Add saturation: A = 16'h7788, B = 16'h1188, sub = 0. Out = 16'h7788: lanes 3 and 2 clamp to 7, lanes 1 and 0 clamp to 8.
- Subtract saturation: A = 16'h8070, B = 16'h1081, sub = 1. Out = 16'h807F (-9 gives 8, 0, 15 gives 7, -1 gives F).
- Backpressure: hold out_ready = 0 for 3 cycles in DONE while pulsing in_valid with new operands. Out stays stable, in_ready = 0, no new op is accepted, and the result drains when out_ready = 1.
- Reset mid-operation: assert rst_n low after 2 CALC cycles. out_valid = 0 and Out = 0. A subsequent op (A = 16'hFFFF, B = 16'h0001, sub = 0) gives Out = 16'h0000.
